// File: rtl/bb_class_vote_argmax.sv
// Classifier back-end: sums one-hot class votes over channels and beats, picks the arg-max
// class, checks it against the label in the user sideband and keeps on-chip accuracy counters.
module bb_class_vote_argmax #(
    parameter int unsigned  CLASS_NUM   = 10,
    parameter int unsigned  CHANNEL_NUM = 1,
    parameter int unsigned  FRAME_NUM   = 1,
    parameter int unsigned  USER_WIDTH  = 8,
    parameter int unsigned  LABEL_WIDTH = 4,
    parameter int unsigned  COUNT_WIDTH = 32,
    localparam int unsigned SUM_WIDTH   = $clog2(CHANNEL_NUM * FRAME_NUM + 1)
) (
    input  logic                             reset_i,
    input  logic                             clk_i,
    input  logic                             cke_i,

    input  logic [USER_WIDTH-1:0]            in_user_i,
    input  logic [CHANNEL_NUM*CLASS_NUM-1:0] in_data_i,
    input  logic                             in_last_i,
    input  logic                             in_valid_i,

    output logic [LABEL_WIDTH-1:0]           out_class_o,
    output logic [SUM_WIDTH-1:0]             out_value_o,
    output logic                             out_none_o,
    output logic                             out_match_o,
    output logic [USER_WIDTH-1:0]            out_user_o,
    output logic                             out_last_o,
    output logic                             out_valid_o,

    input  logic                             stat_clear_i,
    output logic [COUNT_WIDTH-1:0]           stat_total_o,
    output logic [COUNT_WIDTH-1:0]           stat_ok_o,
    output logic                             stat_done_o
);

    localparam int unsigned BCNT_WIDTH = (FRAME_NUM > 1) ? $clog2(FRAME_NUM) : 1;
    localparam logic [BCNT_WIDTH-1:0] BcntLast = BCNT_WIDTH'(FRAME_NUM - 1);

    // ------------------------------------------------------------------
    // Stage A: per-class popcount and temporal accumulation
    // ------------------------------------------------------------------
    logic [BCNT_WIDTH-1:0] bcnt_q, bcnt_d;
    logic [SUM_WIDTH-1:0]  pop   [CLASS_NUM];
    logic [SUM_WIDTH-1:0]  acc_q [CLASS_NUM];
    logic [SUM_WIDTH-1:0]  acc_d [CLASS_NUM];
    logic                  final_beat;

    logic                  done_a_q;
    logic [USER_WIDTH-1:0] user_a_q;
    logic                  last_a_q;

    always_comb begin
        for (int unsigned c = 0; c < CLASS_NUM; c++) begin
            pop[c] = '0;
            for (int unsigned ch = 0; ch < CHANNEL_NUM; ch++) begin
                pop[c] = pop[c] + SUM_WIDTH'(in_data_i[ch*CLASS_NUM + c]);
            end
        end
    end

    always_comb begin
        final_beat = in_valid_i && (bcnt_q == BcntLast);
        bcnt_d     = bcnt_q;
        if (in_valid_i) begin
            bcnt_d = final_beat ? '0 : bcnt_q + 1'b1;
        end
        // First beat of a sample restarts the sums instead of adding to stale ones
        for (int unsigned c = 0; c < CLASS_NUM; c++) begin
            acc_d[c] = acc_q[c];
            if (in_valid_i) begin
                acc_d[c] = (bcnt_q == '0) ? pop[c] : acc_q[c] + pop[c];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bcnt_q   <= '0;
            done_a_q <= 1'b0;
            user_a_q <= '0;
            last_a_q <= 1'b0;
            for (int unsigned c = 0; c < CLASS_NUM; c++) begin
                acc_q[c] <= '0;
            end
        end else if (cke_i) begin
            bcnt_q   <= bcnt_d;
            done_a_q <= final_beat;
            for (int unsigned c = 0; c < CLASS_NUM; c++) begin
                acc_q[c] <= acc_d[c];
            end
            if (final_beat) begin
                user_a_q <= in_user_i;
                last_a_q <= in_last_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage B: arg-max scan and label compare
    // ------------------------------------------------------------------
    logic [SUM_WIDTH-1:0]   best_val;
    logic [LABEL_WIDTH-1:0] best_cls;
    logic                   best_none;
    logic                   best_match;

    always_comb begin
        best_val = acc_q[0];
        best_cls = '0;
        // Strictly greater keeps the lowest index on ties
        for (int unsigned c = 1; c < CLASS_NUM; c++) begin
            if (acc_q[c] > best_val) begin
                best_val = acc_q[c];
                best_cls = LABEL_WIDTH'(c);
            end
        end
        best_none  = (best_val == '0);
        best_match = !best_none && (best_cls == user_a_q[LABEL_WIDTH-1:0]);
    end

    logic [LABEL_WIDTH-1:0] out_class_q;
    logic [SUM_WIDTH-1:0]   out_value_q;
    logic                   out_none_q;
    logic                   out_match_q;
    logic [USER_WIDTH-1:0]  out_user_q;
    logic                   out_last_q;
    logic                   out_valid_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_class_q <= '0;
            out_value_q <= '0;
            out_none_q  <= 1'b0;
            out_match_q <= 1'b0;
            out_user_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (cke_i) begin
            out_valid_q <= done_a_q;
            if (done_a_q) begin
                out_class_q <= best_cls;
                out_value_q <= best_val;
                out_none_q  <= best_none;
                out_match_q <= best_match;
                out_user_q  <= user_a_q;
                out_last_q  <= last_a_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic [COUNT_WIDTH-1:0] stat_total_q, stat_total_d;
    logic [COUNT_WIDTH-1:0] stat_ok_q, stat_ok_d;
    logic                   stat_done_q, stat_done_d;

    always_comb begin
        stat_total_d = stat_total_q;
        stat_ok_d    = stat_ok_q;
        stat_done_d  = stat_done_q;
        if (stat_clear_i) begin
            stat_total_d = '0;
            stat_ok_d    = '0;
            stat_done_d  = 1'b0;
        end else if (out_valid_q) begin
            if (stat_total_q != '1) begin
                stat_total_d = stat_total_q + 1'b1;
            end
            if (out_match_q && (stat_ok_q != '1)) begin
                stat_ok_d = stat_ok_q + 1'b1;
            end
            if (out_last_q) begin
                stat_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stat_total_q <= '0;
            stat_ok_q    <= '0;
            stat_done_q  <= 1'b0;
        end else if (cke_i) begin
            stat_total_q <= stat_total_d;
            stat_ok_q    <= stat_ok_d;
            stat_done_q  <= stat_done_d;
        end
    end

    assign out_class_o  = out_class_q;
    assign out_value_o  = out_value_q;
    assign out_none_o   = out_none_q;
    assign out_match_o  = out_match_q;
    assign out_user_o   = out_user_q;
    assign out_last_o   = out_last_q;
    assign out_valid_o  = out_valid_q;
    assign stat_total_o = stat_total_q;
    assign stat_ok_o    = stat_ok_q;
    assign stat_done_o  = stat_done_q;

endmodule
